// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command issuer: opcodes, flag bit positions and FSM encoding.
package alu_pkg;

  localparam int unsigned OPC_W   = 4;
  localparam int unsigned SHIFT_W = 5;
  localparam int unsigned FLAG_W  = 4;

  localparam logic [OPC_W-1:0] OPC_ADD = 4'd0;
  localparam logic [OPC_W-1:0] OPC_SUB = 4'd1;
  localparam logic [OPC_W-1:0] OPC_AND = 4'd2;
  localparam logic [OPC_W-1:0] OPC_OR  = 4'd3;
  localparam logic [OPC_W-1:0] OPC_SRA = 4'd4;
  localparam logic [OPC_W-1:0] OPC_NOR = 4'd5;
  localparam logic [OPC_W-1:0] OPC_MAX = OPC_NOR;

  // Bit positions inside the packed {sign,overflow,zero,carry} flag vector
  localparam int unsigned FLG_C = 0;
  localparam int unsigned FLG_Z = 1;
  localparam int unsigned FLG_V = 2;
  localparam int unsigned FLG_S = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  // Opcodes above OPC_MAX are answered locally with an illegal response
  function automatic logic opc_legal(input logic [OPC_W-1:0] op);
    return (op <= OPC_MAX);
  endfunction

endpackage

// File: rtl/alu_cmd_issuer.sv
// Initiator for an external combinational ALU: accepts one tagged command, drives the
// ALU inputs from registers, captures result/flags after a settle time and returns a
// tagged response.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   cmd_valid/cmd_ready            command handshake; cmd_opcode/a/b/shift/tag payload
//   alu_opcode/input1/input2/shiftValue   registered drive into the ALU
//   alu_result, alu_*Flag          ALU outputs, sampled at capture
//   rsp_valid/rsp_ready            response handshake; rsp_result/flags/tag/illegal payload
//   op_count                       responses completed since reset (wrapping)
module alu_cmd_issuer
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH      = 64,
  parameter int unsigned TAG_W      = 4,
  parameter int unsigned SETTLE_CYC = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [OPC_W-1:0]   cmd_opcode,
  input  logic [WIDTH-1:0]   cmd_a,
  input  logic [WIDTH-1:0]   cmd_b,
  input  logic [SHIFT_W-1:0] cmd_shift,
  input  logic [TAG_W-1:0]   cmd_tag,
  output logic [OPC_W-1:0]   alu_opcode,
  output logic [WIDTH-1:0]   alu_input1,
  output logic [WIDTH-1:0]   alu_input2,
  output logic [SHIFT_W-1:0] alu_shiftValue,
  input  logic [WIDTH-1:0]   alu_result,
  input  logic               alu_carryFlag,
  input  logic               alu_zeroFlag,
  input  logic               alu_overFlowFlag,
  input  logic               alu_signFlag,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [WIDTH-1:0]   rsp_result,
  output logic [FLAG_W-1:0]  rsp_flags,
  output logic [TAG_W-1:0]   rsp_tag,
  output logic               rsp_illegal,
  output logic [CNT_W-1:0]   op_count
);

  localparam int unsigned SCNT_W = 4;

  state_t              state;
  state_t              state_nxt;
  logic [SCNT_W-1:0]   settle_q;
  logic [SCNT_W-1:0]   settle_d;
  logic [TAG_W-1:0]    tag_q;
  logic [TAG_W-1:0]    tag_d;

  logic                cmd_ready_d;
  logic [OPC_W-1:0]    alu_opcode_d;
  logic [WIDTH-1:0]    alu_input1_d;
  logic [WIDTH-1:0]    alu_input2_d;
  logic [SHIFT_W-1:0]  alu_shift_d;
  logic                rsp_valid_d;
  logic [WIDTH-1:0]    rsp_result_d;
  logic [FLAG_W-1:0]   rsp_flags_d;
  logic [TAG_W-1:0]    rsp_tag_d;
  logic                rsp_illegal_d;
  logic [CNT_W-1:0]    op_count_d;

  logic                accept;
  logic                rsp_done;
  logic                cmd_legal;

  assign accept    = cmd_valid & cmd_ready;
  assign rsp_done  = rsp_valid & rsp_ready;
  assign cmd_legal = opc_legal(cmd_opcode);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept) state_nxt = cmd_legal ? ST_DRIVE : ST_RESP;
      ST_DRIVE: if (settle_q == '0) state_nxt = ST_RESP;
      ST_RESP:  if (rsp_done) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Next values for the registered outputs and datapath
  always_comb begin
    settle_d      = settle_q;
    tag_d         = tag_q;
    alu_opcode_d  = alu_opcode;
    alu_input1_d  = alu_input1;
    alu_input2_d  = alu_input2;
    alu_shift_d   = alu_shiftValue;
    rsp_result_d  = rsp_result;
    rsp_flags_d   = rsp_flags;
    rsp_tag_d     = rsp_tag;
    rsp_illegal_d = rsp_illegal;
    op_count_d    = op_count;
    // Handshake qualifiers track the state being entered so they line up with it
    cmd_ready_d   = (state_nxt == ST_IDLE);
    rsp_valid_d   = (state_nxt == ST_RESP);

    case (state)
      ST_IDLE: begin
        if (accept) begin
          alu_opcode_d = cmd_opcode;
          alu_input1_d = cmd_a;
          alu_input2_d = cmd_b;
          alu_shift_d  = cmd_shift;
          tag_d        = cmd_tag;
          if (cmd_legal) begin
            settle_d = SCNT_W'(SETTLE_CYC - 1);
          end else begin
            // Illegal opcode: answer immediately, ALU output is never sampled
            rsp_result_d  = '0;
            rsp_flags_d   = '0;
            rsp_tag_d     = cmd_tag;
            rsp_illegal_d = 1'b1;
          end
        end
      end
      ST_DRIVE: begin
        if (settle_q == '0) begin
          rsp_result_d         = alu_result;
          rsp_flags_d[FLG_C]   = alu_carryFlag;
          rsp_flags_d[FLG_Z]   = alu_zeroFlag;
          rsp_flags_d[FLG_V]   = alu_overFlowFlag;
          rsp_flags_d[FLG_S]   = alu_signFlag;
          rsp_tag_d            = tag_q;
          rsp_illegal_d        = 1'b0;
        end else begin
          settle_d = settle_q - SCNT_W'(1);
        end
      end
      ST_RESP: begin
        if (rsp_done) op_count_d = op_count + CNT_W'(1);
      end
      default: ;
    endcase
  end

  // Output and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_q       <= '0;
      tag_q          <= '0;
      cmd_ready      <= 1'b0;
      alu_opcode     <= '0;
      alu_input1     <= '0;
      alu_input2     <= '0;
      alu_shiftValue <= '0;
      rsp_valid      <= 1'b0;
      rsp_result     <= '0;
      rsp_flags      <= '0;
      rsp_tag        <= '0;
      rsp_illegal    <= 1'b0;
      op_count       <= '0;
    end else begin
      settle_q       <= settle_d;
      tag_q          <= tag_d;
      cmd_ready      <= cmd_ready_d;
      alu_opcode     <= alu_opcode_d;
      alu_input1     <= alu_input1_d;
      alu_input2     <= alu_input2_d;
      alu_shiftValue <= alu_shift_d;
      rsp_valid      <= rsp_valid_d;
      rsp_result     <= rsp_result_d;
      rsp_flags      <= rsp_flags_d;
      rsp_tag        <= rsp_tag_d;
      rsp_illegal    <= rsp_illegal_d;
      op_count       <= op_count_d;
    end
  end

endmodule
